// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the instruction-cache geometry, tag/index types and
// the controller state encoding.
package lc3b_types;
    localparam int ICACHE_OFFSET_BITS = 4;
    localparam int ICACHE_INDEX_BITS  = 3;
    localparam int ICACHE_NUM_SETS    = 1 << ICACHE_INDEX_BITS;
    localparam int ICACHE_TAG_BITS    = 16 - ICACHE_INDEX_BITS - ICACHE_OFFSET_BITS;

    typedef logic [127:0]                 lc3b_data;
    typedef logic [15:0]                  lc3b_word;
    typedef logic [ICACHE_TAG_BITS-1:0]   icache_tag;
    typedef logic [ICACHE_INDEX_BITS-1:0] icache_index;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state;
endpackage

// File: rtl/icache_array.sv
// Per-set storage: combinational read, registered write, whole-array
// synchronous clear that wins over a same-cycle write.
module icache_array #(
    parameter int WIDTH      = 1,
    parameter int DEPTH      = 8,
    parameter int INDEX_BITS = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  write,
    input  logic [INDEX_BITS-1:0] read_index,
    input  logic [INDEX_BITS-1:0] write_index,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (write) begin
            mem[write_index] <= wdata;
        end
    end

    assign rdata = mem[read_index];
endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped, read-only instruction cache with zero-wait hits and a
// blocking, non-cancellable line fill from the memory port.
module icache_direct_mapped
    import lc3b_types::*;
#(
    parameter int NUM_SETS    = ICACHE_NUM_SETS,
    parameter int INDEX_BITS  = ICACHE_INDEX_BITS,
    parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
    parameter int TAG_BITS    = 16 - INDEX_BITS - OFFSET_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  imem_address,
    input  logic         imem_action_stb,
    input  logic         imem_action_cyc,
    output logic [127:0] imem_rdata,
    output logic         imem_resp,
    output logic         imem_retry,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);
    icache_state           state;
    logic                  req;
    logic                  hit;
    logic                  fill_write;
    logic [INDEX_BITS-1:0] index;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   tag;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [TAG_BITS-1:0]   stored_tag;
    logic                  stored_valid;
    lc3b_data              stored_data;
    logic                  unused_offset;

    assign tag           = imem_address[15 -: TAG_BITS];
    assign index         = imem_address[OFFSET_BITS +: INDEX_BITS];
    assign unused_offset = ^imem_address[OFFSET_BITS-1:0];

    // The registered fill address doubles as the latched line being filled.
    assign fill_tag   = pmem_address[15 -: TAG_BITS];
    assign fill_index = pmem_address[OFFSET_BITS +: INDEX_BITS];
    assign fill_write = (state == FILL) && pmem_resp;

    icache_array #(.WIDTH(128), .DEPTH(NUM_SETS), .INDEX_BITS(INDEX_BITS)) data_array (
        .clk(clk), .clear(rst), .write(fill_write), .read_index(index),
        .write_index(fill_index), .wdata(pmem_rdata), .rdata(stored_data)
    );

    icache_array #(.WIDTH(TAG_BITS), .DEPTH(NUM_SETS), .INDEX_BITS(INDEX_BITS)) tag_array (
        .clk(clk), .clear(rst), .write(fill_write), .read_index(index),
        .write_index(fill_index), .wdata(fill_tag), .rdata(stored_tag)
    );

    icache_array #(.WIDTH(1), .DEPTH(NUM_SETS), .INDEX_BITS(INDEX_BITS)) valid_array (
        .clk(clk), .clear(rst), .write(fill_write), .read_index(index),
        .write_index(fill_index), .wdata(1'b1), .rdata(stored_valid)
    );

    assign req        = imem_action_stb & imem_action_cyc;
    assign hit        = req & stored_valid & (stored_tag == tag);
    assign imem_resp  = ~rst & (state == IDLE) & hit;
    assign imem_retry = ~rst & req & ~imem_resp;
    assign imem_rdata = imem_resp ? stored_data : '0;

    // Once FILL is entered only pmem_resp or reset can leave it, so the
    // memory-side request stays stable regardless of the CPU inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_address <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            if (imem_resp && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        state        <= FILL;
                        pmem_read    <= 1'b1;
                        pmem_address <= {tag, index, {OFFSET_BITS{1'b0}}};
                        if (miss_count != 16'hFFFF) begin
                            miss_count <= miss_count + 16'd1;
                        end
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        state     <= IDLE;
                        pmem_read <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench: scoreboard of expected lines, an auto-responding memory
// model with fixed latency, and a per-cycle monitor on resp/retry exclusivity.
module tb_icache_direct_mapped;
    localparam int PMEM_LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  imem_address;
    logic         imem_action_stb;
    logic         imem_action_cyc;
    logic [127:0] imem_rdata;
    logic         imem_resp;
    logic         imem_retry;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;

    int           checks = 0;
    int           errors = 0;
    int           exp_hits = 0;
    int           exp_misses = 0;
    int           pmem_wait = 0;
    bit           auto_pmem = 1'b1;
    logic [127:0] sb_queue [$];

    icache_direct_mapped dut (
        .clk(clk), .rst(rst), .imem_address(imem_address),
        .imem_action_stb(imem_action_stb), .imem_action_cyc(imem_action_cyc),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .imem_retry(imem_retry),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [15:0] a);
        return {8{{a[15:4], 4'hA}}};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic checkCounters(input string name);
        checkOutput({name, "_hit_count"}, hit_count, exp_hits);
        checkOutput({name, "_miss_count"}, miss_count, exp_misses);
    endtask

    // Issues one fetch and holds it until served; call and return at posedge+1.
    task automatic applyStimulus(input logic [15:0] addr, input bit exp_hit, input string name);
        int           cycles;
        bit           done;
        logic [127:0] want;
        sb_queue.push_back(line_of(addr));
        imem_address    = addr;
        imem_action_stb = 1'b1;
        imem_action_cyc = 1'b1;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 40) begin
            @(negedge clk);
            if (cycles == 0) begin
                checkOutput({name, "_hit"}, imem_resp, exp_hit);
                if (exp_hit) checkOutput({name, "_no_pmem_read"}, pmem_read, 1'b0);
            end
            if (imem_resp) begin
                want = sb_queue.pop_front();
                checkOutput({name, "_rdata"}, imem_rdata, want);
                checkOutput({name, "_latency"}, cycles, exp_hit ? 0 : PMEM_LAT + 1);
                done = 1'b1;
                if (exp_hits < 65535) exp_hits++;
                if (!exp_hit) exp_misses++;
            end else if (pmem_read) begin
                checkOutput({name, "_fill_addr"}, pmem_address, {addr[15:4], 4'h0});
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) begin
            checkOutput({name, "_timeout"}, 0, 1);
            if (sb_queue.size() > 0) want = sb_queue.pop_front();
        end
        imem_action_stb = 1'b0;
        imem_action_cyc = 1'b0;
    endtask

    // Memory model: answers a held pmem_read with a one-cycle pulse.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_pmem) begin
                pmem_resp = 1'b0;
                if (pmem_read) begin
                    pmem_wait++;
                    if (pmem_wait == PMEM_LAT) begin
                        pmem_resp  = 1'b1;
                        pmem_rdata = line_of(pmem_address);
                        pmem_wait  = 0;
                    end
                end else begin
                    pmem_wait = 0;
                end
            end else begin
                pmem_wait = 0;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("resp_retry_excl", imem_resp & imem_retry, 0);
        checkOutput("quiet_without_req", (imem_resp | imem_retry) & ~(imem_action_stb & imem_action_cyc), 0);
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        bit filled;
        rst             = 1'b1;
        imem_address    = '0;
        imem_action_stb = 1'b0;
        imem_action_cyc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_resp", imem_resp, 0);
        checkOutput("reset_retry", imem_retry, 0);
        checkOutput("reset_pmem_read", pmem_read, 0);
        checkOutput("reset_pmem_address", pmem_address, 0);
        checkOutput("reset_rdata", imem_rdata, 0);
        checkCounters("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus(16'h0040, 1'b0, "cold_miss");
        checkCounters("cold_miss");
        applyStimulus(16'h004E, 1'b1, "offset_hit");
        checkCounters("offset_hit");
        applyStimulus(16'h00C0, 1'b0, "conflict_fill");
        applyStimulus(16'h0040, 1'b0, "evicted");
        checkCounters("conflict");

        // Flush mid-fill: CPU drops cyc and moves the address during FILL.
        imem_address    = 16'h0100;
        imem_action_stb = 1'b1;
        imem_action_cyc = 1'b1;
        @(negedge clk);
        checkOutput("flush_retry", imem_retry, 1);
        exp_misses++;
        @(posedge clk);
        #1;
        cycles = 1;
        filled = 1'b0;
        while (!filled && cycles < 40) begin
            if (cycles == 2) begin
                imem_action_cyc = 1'b0;
                imem_address    = 16'h0A30;
            end
            @(negedge clk);
            if (pmem_resp) filled = 1'b1;
            checkOutput("flush_pmem_read", pmem_read, 1);
            checkOutput("flush_pmem_address", pmem_address, 16'h0100);
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!filled) checkOutput("flush_timeout", 0, 1);
        imem_action_stb = 1'b0;
        imem_action_cyc = 1'b0;
        applyStimulus(16'h0100, 1'b1, "post_flush_hit");
        checkCounters("post_flush");

        // Reset lands in the same cycle as pmem_resp: nothing may be installed.
        imem_address    = 16'h0200;
        imem_action_stb = 1'b1;
        imem_action_cyc = 1'b1;
        @(negedge clk);
        checkOutput("rstfill_retry", imem_retry, 1);
        auto_pmem = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst             = 1'b1;
        pmem_resp       = 1'b1;
        pmem_rdata      = line_of(16'h0200);
        imem_action_stb = 1'b0;
        imem_action_cyc = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pmem_resp = 1'b0;
        auto_pmem = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clk);
        checkOutput("rstfill_pmem_read", pmem_read, 0);
        checkCounters("rstfill");
        @(posedge clk);
        #1;
        applyStimulus(16'h0200, 1'b0, "rst_no_write");
        applyStimulus(16'h0040, 1'b0, "rst_invalid");
        checkCounters("after_rst");

        // Saturation: hold a resident line for 70000 consecutive hits.
        imem_address    = 16'h0040;
        imem_action_stb = 1'b1;
        imem_action_cyc = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        imem_action_stb = 1'b0;
        imem_action_cyc = 1'b0;
        exp_hits = (exp_hits + 70000 > 65535) ? 65535 : exp_hits + 70000;
        checkCounters("saturate");
        checkOutput("sb_empty", sb_queue.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
